// File: rtl/tournament_grant_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : pkg_bram_if                                                      |
// | Purpose  : Shared types and sizes for the tournament grant controller.      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package pkg_bram_if;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH_UNITS = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tournament_grant_ctrl_pick.sv
// +----------------------------------------------------------------------------+
// | Module   : PriorityPick                                                     |
// | Purpose  : Combinational lowest-set-bit one-hot picker.                     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module PriorityPick #(
    parameter int N = 4
) (
    input  logic [N-1:0] cand,
    output logic [N-1:0] pick
);

    // Two's-complement trick isolates the least significant set bit.
    assign pick = cand & (~cand + {{(N-1){1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/tournament_grant_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tournament_grant_ctrl                                            |
// | Purpose  : Registered grant/hold/release controller behind the tournament   |
// |            selector. Optional forced release: TOURNAMENT_GRANT_TIMEOUT_EN.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tournament_grant_ctrl #(
    parameter int NUM_REQ  = pkg_bram_if::NUM_REQ,
    parameter int HOLD_MAX = 16,
    parameter int WHOLD    = $clog2(HOLD_MAX) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            I_Valid,
    input  logic [NUM_REQ-1:0]              I_Win,
    input  logic [pkg_bram_if::WIDTH_UNITS:0] I_Entry,
    input  logic [NUM_REQ-1:0]              I_Req,
    input  logic [NUM_REQ-1:0]              I_Release,
    output logic [NUM_REQ-1:0]              O_Grant,
    output logic [pkg_bram_if::WIDTH_UNITS:0] O_Entry,
    output logic                            O_Busy,
    output logic                            O_Timeout
);

    import pkg_bram_if::*;

    localparam logic [WHOLD-1:0] c_hold_max = WHOLD'(HOLD_MAX);

    state_t                 r_state, w_state_n;
    logic [NUM_REQ-1:0]     r_owner, w_owner_n;
    logic [WHOLD-1:0]       r_cnt, w_cnt_n;
    logic                   r_rel_pend, w_rel_pend_n;
    logic [WIDTH_UNITS:0]   w_entry_n;
    logic [NUM_REQ-1:0]     w_grant_n;
    logic                   w_busy_n, w_timeout_n;
    logic [NUM_REQ-1:0]     w_cand, w_pick;
    logic                   w_owner_rel, w_owner_drop;

    assign w_cand       = I_Win & I_Req;
    assign w_owner_rel  = |(I_Release & r_owner);
    assign w_owner_drop = ~|(I_Req & r_owner);

    PriorityPick #(.N(NUM_REQ)) u_pick (
        .cand (w_cand),
        .pick (w_pick)
    );

    always_comb begin
        w_state_n    = r_state;
        w_owner_n    = r_owner;
        w_cnt_n      = r_cnt;
        w_rel_pend_n = 1'b0;
        w_entry_n    = O_Entry;
        w_timeout_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (I_Valid && (|w_cand)) begin
                    w_state_n = GRANT;
                    w_owner_n = w_pick;
                    w_entry_n = I_Entry;
                    w_cnt_n   = '0;
                end
            end
            GRANT: begin
                w_state_n    = HOLD;
                w_cnt_n      = {{(WHOLD-1){1'b0}}, 1'b1};
                // A release pulse during GRANT is carried into the first HOLD decision.
                w_rel_pend_n = w_owner_rel;
            end
            HOLD: begin
                if (r_cnt != c_hold_max)
                    w_cnt_n = r_cnt + {{(WHOLD-1){1'b0}}, 1'b1};
                if (w_owner_rel || w_owner_drop || r_rel_pend) begin
                    w_state_n = RELEASE;
`ifdef TOURNAMENT_GRANT_TIMEOUT_EN
                end else if (r_cnt == c_hold_max) begin
                    w_state_n   = RELEASE;
                    w_timeout_n = 1'b1;
`endif
                end
            end
            RELEASE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        w_busy_n  = (w_state_n == GRANT) || (w_state_n == HOLD);
        w_grant_n = w_busy_n ? w_owner_n : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_rel_pend <= 1'b0;
            O_Grant    <= '0;
            O_Entry    <= '0;
            O_Busy     <= 1'b0;
            O_Timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_owner    <= w_owner_n;
            r_cnt      <= w_cnt_n;
            r_rel_pend <= w_rel_pend_n;
            O_Grant    <= w_grant_n;
            O_Entry    <= w_entry_n;
            O_Busy     <= w_busy_n;
            O_Timeout  <= w_timeout_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tournament_grant_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_tournament_grant_ctrl                                         |
// | Purpose  : Directed self-checking bench for tournament_grant_ctrl.          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tournament_grant_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       I_Valid;
    logic [3:0] I_Win, I_Req, I_Release;
    logic [7:0] I_Entry;
    logic [3:0] O_Grant;
    logic [7:0] O_Entry;
    logic       O_Busy, O_Timeout;

    int checks = 0;
    int errors = 0;

    tournament_grant_ctrl #(.NUM_REQ(4), .HOLD_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Valid   (I_Valid),
        .I_Win     (I_Win),
        .I_Entry   (I_Entry),
        .I_Req     (I_Req),
        .I_Release (I_Release),
        .O_Grant   (O_Grant),
        .O_Entry   (O_Entry),
        .O_Busy    (O_Busy),
        .O_Timeout (O_Timeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; I_Valid = 1'b0; I_Win = '0; I_Req = '0; I_Release = '0; I_Entry = '0;
        step(); step();
        reset = 1'b0;
        check("rst_grant", 32'(O_Grant), 0);
        check("rst_entry", 32'(O_Entry), 0);
        check("rst_busy", 32'(O_Busy), 0);
        check("rst_timeout", 32'(O_Timeout), 0);

        // Single capture of entry 2
        I_Valid = 1'b1; I_Win = 4'b0100; I_Req = 4'b0100; I_Entry = 8'h05;
        step();
        I_Valid = 1'b0; I_Win = '0;
        check("cap_grant", 32'(O_Grant), 32'h4);
        check("cap_entry", 32'(O_Entry), 32'h05);
        check("cap_busy", 32'(O_Busy), 1);
        step(); step();
        check("hold_grant", 32'(O_Grant), 32'h4);

        // Foreign release is ignored
        I_Release = 4'b0001;
        step();
        I_Release = '0;
        check("foreign_rel", 32'(O_Grant), 32'h4);

        // Owner release: gap then re-grant at r+3
        I_Release = 4'b0100;
        step();
        I_Release = '0;
        check("rel_r1_grant", 32'(O_Grant), 0);
        check("rel_r1_busy", 32'(O_Busy), 0);
        I_Valid = 1'b1; I_Win = 4'b0100; I_Entry = 8'h3C;
        step();
        check("rel_r2_grant", 32'(O_Grant), 0);
        check("rel_r2_entry", 32'(O_Entry), 32'h05);
        step();
        I_Valid = 1'b0; I_Win = '0;
        check("rel_r3_grant", 32'(O_Grant), 32'h4);
        check("rel_r3_entry", 32'(O_Entry), 32'h3C);
        step();

        // Request drop
        I_Req = 4'b0000;
        step();
        check("drop_grant", 32'(O_Grant), 0);
        check("drop_entry_kept", 32'(O_Entry), 32'h3C);
        step();

        // Non-one-hot win: lowest index wins
        I_Valid = 1'b1; I_Win = 4'b1010; I_Req = 4'b1111; I_Entry = 8'h81;
        step();
        I_Valid = 1'b0; I_Win = '0;
        check("multi_grant", 32'(O_Grant), 32'h2);
        check("multi_entry", 32'(O_Entry), 32'h81);
`ifndef TOURNAMENT_GRANT_TIMEOUT_EN
        for (int i = 0; i < 8; i++) step();
        check("long_hold_grant", 32'(O_Grant), 32'h2);
        check("long_hold_timeout", 32'(O_Timeout), 0);
`endif
        I_Release = 4'b0010;
        step();
        I_Release = '0;
        check("multi_rel", 32'(O_Grant), 0);
        step();

        // Release pulsed during GRANT is honoured at first HOLD evaluation
        I_Valid = 1'b1; I_Win = 4'b0001; I_Req = 4'b0001; I_Entry = 8'h11;
        step();
        I_Valid = 1'b0; I_Win = '0; I_Release = 4'b0001;
        step();
        I_Release = '0;
        check("grel_hold1", 32'(O_Grant), 32'h1);
        step();
        check("grel_release", 32'(O_Grant), 0);
        step();

`ifdef TOURNAMENT_GRANT_TIMEOUT_EN
        // Forced release after GRANT + 4 HOLD cycles
        I_Valid = 1'b1; I_Win = 4'b1000; I_Req = 4'b1000; I_Entry = 8'h22;
        step();
        I_Valid = 1'b0; I_Win = '0;
        for (int i = 0; i < 5; i++) begin
            check("to_grant_held", 32'(O_Grant), 32'h8);
            if (i < 4) step();
        end
        step();
        check("to_grant_off", 32'(O_Grant), 0);
        check("to_pulse", 32'(O_Timeout), 1);
        step();
        check("to_pulse_end", 32'(O_Timeout), 0);
        // Release on the final hold cycle wins over the timeout
        I_Valid = 1'b1; I_Win = 4'b1000;
        step();
        I_Valid = 1'b0; I_Win = '0;
        for (int i = 0; i < 4; i++) step();
        I_Release = 4'b1000;
        step();
        I_Release = '0;
        check("to_rel_grant", 32'(O_Grant), 0);
        check("to_rel_no_pulse", 32'(O_Timeout), 0);
        step();
`endif

        // Reset asserted mid-hold
        I_Valid = 1'b1; I_Win = 4'b0001; I_Req = 4'b0001; I_Entry = 8'h55;
        step();
        I_Valid = 1'b0; I_Win = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_grant", 32'(O_Grant), 0);
        check("mid_rst_busy", 32'(O_Busy), 0);
        check("mid_rst_entry", 32'(O_Entry), 0);
        check("mid_rst_timeout", 32'(O_Timeout), 0);
        step();
        check("mid_rst_idle", 32'(O_Busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
